// File: rtl/pixel_sequencer.sv
// pixel_sequencer
//   Runtime-programmable phase sequencer for a pixel array. Walks through
//   ERASE -> EXPOSE -> CONVERT -> READ(0..N_READ-1), with a one-cycle
//   all-low GAP after every phase. Phase durations are taken from shadow
//   registers that are refreshed from the live config at each frame start.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start, continuous   : frame start (IDLE only) / auto-restart at frame end
//   abort               : return to IDLE at once, no frame_done
//   cfg_we, cfg_*       : write live duration registers (any state)
//   erase, expose,
//   convert, read       : registered, mutually exclusive phase strobes
//   busy, frame_done    : frame in progress / one-cycle end-of-frame pulse
module pixel_sequencer #(
  parameter int CNT_W       = 8,
  parameter int N_READ      = 2,
  parameter int DEF_ERASE   = 5,
  parameter int DEF_EXPOSE  = 255,
  parameter int DEF_CONVERT = 255,
  parameter int DEF_READ    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_erase,
  input  logic [CNT_W-1:0]  cfg_expose,
  input  logic [CNT_W-1:0]  cfg_convert,
  input  logic [CNT_W-1:0]  cfg_read,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic [N_READ-1:0] read,
  output logic              busy,
  output logic              frame_done
);

  localparam int RD_W = (N_READ > 1) ? $clog2(N_READ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  // Counter load value: a programmed 0 behaves as a 1-cycle phase.
  function automatic logic [CNT_W-1:0] dur_m1(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b0}}) begin
      dur_m1 = {CNT_W{1'b0}};
    end else begin
      dur_m1 = v - CNT_W'(1);
    end
  endfunction

  state_t            state_q, state_d;
  state_t            next_q, next_d;     // successor of the current GAP; S_IDLE marks the final GAP
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_W-1:0]   rd_idx_q, rd_idx_d;

  logic [CNT_W-1:0]  live_erase_q, live_erase_d, live_expose_q, live_expose_d;
  logic [CNT_W-1:0]  live_convert_q, live_convert_d, live_read_q, live_read_d;
  logic [CNT_W-1:0]  sh_erase_q, sh_erase_d, sh_expose_q, sh_expose_d;
  logic [CNT_W-1:0]  sh_convert_q, sh_convert_d, sh_read_q, sh_read_d;

  logic              erase_q, erase_d, expose_q, expose_d, convert_q, convert_d;
  logic [N_READ-1:0] read_q, read_d;
  logic              busy_q, busy_d, frame_done_q, frame_done_d;

  // State, config and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      next_q         <= S_ERASE;
      cnt_q          <= {CNT_W{1'b0}};
      rd_idx_q       <= {RD_W{1'b0}};
      live_erase_q   <= CNT_W'(DEF_ERASE);
      live_expose_q  <= CNT_W'(DEF_EXPOSE);
      live_convert_q <= CNT_W'(DEF_CONVERT);
      live_read_q    <= CNT_W'(DEF_READ);
      sh_erase_q     <= CNT_W'(DEF_ERASE);
      sh_expose_q    <= CNT_W'(DEF_EXPOSE);
      sh_convert_q   <= CNT_W'(DEF_CONVERT);
      sh_read_q      <= CNT_W'(DEF_READ);
      erase_q        <= 1'b0;
      expose_q       <= 1'b0;
      convert_q      <= 1'b0;
      read_q         <= {N_READ{1'b0}};
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_q         <= next_d;
      cnt_q          <= cnt_d;
      rd_idx_q       <= rd_idx_d;
      live_erase_q   <= live_erase_d;
      live_expose_q  <= live_expose_d;
      live_convert_q <= live_convert_d;
      live_read_q    <= live_read_d;
      sh_erase_q     <= sh_erase_d;
      sh_expose_q    <= sh_expose_d;
      sh_convert_q   <= sh_convert_d;
      sh_read_q      <= sh_read_d;
      erase_q        <= erase_d;
      expose_q       <= expose_d;
      convert_q      <= convert_d;
      read_q         <= read_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Next-state, counter, read index and config register update.
  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    sh_erase_d   = sh_erase_q;
    sh_expose_d  = sh_expose_q;
    sh_convert_d = sh_convert_q;
    sh_read_d    = sh_read_q;

    if (cfg_we) begin
      live_erase_d   = cfg_erase;
      live_expose_d  = cfg_expose;
      live_convert_d = cfg_convert;
      live_read_d    = cfg_read;
    end else begin
      live_erase_d   = live_erase_q;
      live_expose_d  = live_expose_q;
      live_convert_d = live_convert_q;
      live_read_d    = live_read_q;
    end

    if (abort) begin
      // Abort also covers IDLE, where it suppresses a simultaneous start.
      state_d  = S_IDLE;
      next_d   = S_ERASE;
      cnt_d    = {CNT_W{1'b0}};
      rd_idx_d = {RD_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d      = S_ERASE;
            sh_erase_d   = live_erase_q;
            sh_expose_d  = live_expose_q;
            sh_convert_d = live_convert_q;
            sh_read_d    = live_read_q;
            cnt_d        = dur_m1(live_erase_q);
            rd_idx_d     = {RD_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ERASE, S_EXPOSE, S_CONVERT, S_READ: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = S_GAP;
            case (state_q)
              S_ERASE:   next_d = S_EXPOSE;
              S_EXPOSE:  next_d = S_CONVERT;
              S_CONVERT: next_d = S_READ;
              default: begin
                if (rd_idx_q == RD_W'(N_READ - 1)) begin
                  next_d = S_IDLE;
                end else begin
                  next_d   = S_READ;
                  rd_idx_d = rd_idx_q + RD_W'(1);
                end
              end
            endcase
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          case (next_q)
            S_EXPOSE: begin
              state_d = S_EXPOSE;
              cnt_d   = dur_m1(sh_expose_q);
            end
            S_CONVERT: begin
              state_d = S_CONVERT;
              cnt_d   = dur_m1(sh_convert_q);
            end
            S_READ: begin
              state_d = S_READ;
              cnt_d   = dur_m1(sh_read_q);
            end
            S_IDLE: begin
              // Final GAP: restart with a fresh config snapshot or stop.
              if (continuous) begin
                state_d      = S_ERASE;
                next_d       = S_ERASE;
                sh_erase_d   = live_erase_q;
                sh_expose_d  = live_expose_q;
                sh_convert_d = live_convert_q;
                sh_read_d    = live_read_q;
                cnt_d        = dur_m1(live_erase_q);
                rd_idx_d     = {RD_W{1'b0}};
              end else begin
                state_d = S_IDLE;
                next_d  = S_ERASE;
              end
            end
            default: begin
              state_d = S_IDLE;
              next_d  = S_ERASE;
            end
          endcase
        end
        default: begin
          state_d = S_IDLE;
          next_d  = S_ERASE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    erase_d      = (state_d == S_ERASE);
    expose_d     = (state_d == S_EXPOSE);
    convert_d    = (state_d == S_CONVERT);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_GAP) && (next_d == S_IDLE);
    read_d       = {N_READ{1'b0}};
    for (int k = 0; k < N_READ; k++) begin
      read_d[k] = (state_d == S_READ) && (rd_idx_d == RD_W'(k));
    end
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read       = read_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer
//   Directed bench for pixel_sequencer (N_READ = 2, CNT_W = 8). Stimulus
//   pushes the expected per-cycle output word into a scoreboard queue; a
//   monitor on the falling edge pops and compares, and also checks strobe
//   exclusivity and break-before-make every checked cycle.
module tb_pixel_sequencer;
  localparam int CNT_W  = 8;
  localparam int N_READ = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, continuous, abort, cfg_we;
  logic [CNT_W-1:0] cfg_erase, cfg_expose, cfg_convert, cfg_read;
  logic erase, expose, convert, busy, frame_done;
  logic [N_READ-1:0] read;

  pixel_sequencer #(.CNT_W(CNT_W), .N_READ(N_READ)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .cfg_we(cfg_we), .cfg_erase(cfg_erase),
    .cfg_expose(cfg_expose), .cfg_convert(cfg_convert), .cfg_read(cfg_read),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .busy(busy), .frame_done(frame_done)
  );

  // Word layout: {erase, expose, convert, read[1], read[0], busy, frame_done}
  localparam logic [6:0] E_IDLE = 7'b0000000;
  localparam logic [6:0] E_ER   = 7'b1000010;
  localparam logic [6:0] E_EX   = 7'b0100010;
  localparam logic [6:0] E_CV   = 7'b0010010;
  localparam logic [6:0] E_R1   = 7'b0001010;
  localparam logic [6:0] E_R0   = 7'b0000110;
  localparam logic [6:0] E_GAP  = 7'b0000010;
  localparam logic [6:0] E_DONE = 7'b0000011;

  logic [6:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_w, got_w;
  logic [4:0] strobes, prev_strobes = 5'b00000;

  // Monitor: compare each checked cycle against the scoreboard head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_w = sb.pop_front();
      got_w = {erase, expose, convert, read[1], read[0], busy, frame_done};
      vectors++;
      if (got_w !== exp_w) begin
        miscompares++;
        $display("FAIL outputs t=%0t got=%b expected=%b", $time, got_w, exp_w);
      end
      strobes = {erase, expose, convert, read};
      vectors++;
      if (!$onehot0(strobes)) begin
        miscompares++;
        $display("FAIL onehot t=%0t strobes=%b expected at most one high", $time, strobes);
      end
      vectors++;
      if (strobes != 5'b00000 && prev_strobes != 5'b00000 && strobes != prev_strobes) begin
        miscompares++;
        $display("FAIL gap t=%0t strobes=%b prev=%b expected an all-low cycle between", $time, strobes, prev_strobes);
      end
      prev_strobes = strobes;
    end
  end

  // Advance one cycle: queue this cycle's expectation, drop pulse inputs.
  task automatic tick(input logic [6:0] e);
    @(posedge clk);
    #1;
    sb.push_back(e);
    start  = 1'b0;
    cfg_we = 1'b0;
    abort  = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic phase(input logic [6:0] e, input int n);
    for (int i = 0; i < n; i++) tick(e);
  endtask

  task automatic reads_done(input int dr);
    tick(E_GAP); phase(E_R0, dr); tick(E_GAP); phase(E_R1, dr); tick(E_DONE);
  endtask

  task automatic tail2(input int dc, input int dr);
    tick(E_GAP); phase(E_CV, dc); reads_done(dr);
  endtask

  task automatic tail(input int dx, input int dc, input int dr);
    tick(E_GAP); phase(E_EX, dx); tail2(dc, dr);
  endtask

  task automatic frame(input int de, input int dx, input int dc, input int dr);
    phase(E_ER, de); tail(dx, dc, dr);
  endtask

  task automatic write_cfg(input int a, input int b, input int c, input int d);
    cfg_erase   = CNT_W'(a);
    cfg_expose  = CNT_W'(b);
    cfg_convert = CNT_W'(c);
    cfg_read    = CNT_W'(d);
    cfg_we      = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t expected run to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_erase = 8'd0; cfg_expose = 8'd0; cfg_convert = 8'd0; cfg_read = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick(E_IDLE);                       // reset state

    // Single shot 2/3/3/1: erase 1-2 ... frame_done 15, idle 16.
    write_cfg(2, 3, 3, 1);
    tick(E_IDLE);
    start = 1'b1;                       // cycle 0
    frame(2, 3, 3, 1);
    tick(E_IDLE);

    // All-zero config: every phase lasts one cycle.
    write_cfg(0, 0, 0, 0);
    tick(E_IDLE);
    start = 1'b1;
    frame(1, 1, 1, 1);
    tick(E_IDLE);

    // All-255 config: full-length phases, counter must not wrap.
    write_cfg(255, 255, 255, 255);
    tick(E_IDLE);
    start = 1'b1;
    frame(255, 255, 255, 255);
    tick(E_IDLE);

    // Continuous: mid-frame write of expose=5 only affects frame 2.
    write_cfg(2, 3, 3, 1);
    continuous = 1'b1;
    tick(E_IDLE);
    start = 1'b1;                       // cycle 0
    phase(E_ER, 2);
    tick(E_GAP);
    phase(E_EX, 3);                     // cycles 4-6
    write_cfg(2, 5, 3, 1);              // during cycle 6
    tail2(3, 1);                        // frame_done at 15
    phase(E_ER, 2);                     // frame 2 erase 16-17
    continuous = 1'b0;
    tail(5, 3, 1);                      // frame_done at 32
    tick(E_IDLE);

    // Abort during CONVERT at cycle 9, restart at cycle 11.
    write_cfg(2, 3, 3, 1);
    tick(E_IDLE);
    start = 1'b1;                       // cycle 0
    phase(E_ER, 2);
    tick(E_GAP);
    phase(E_EX, 3);
    tick(E_GAP);
    phase(E_CV, 2);                     // cycles 8-9
    abort = 1'b1;
    tick(E_IDLE);                       // cycle 10
    tick(E_IDLE);                       // cycle 11
    start = 1'b1;
    frame(2, 3, 3, 1);                  // erase from cycle 12
    tick(E_IDLE);

    // Abort in IDLE blocks a simultaneous start.
    start = 1'b1;
    abort = 1'b1;
    tick(E_IDLE);
    tick(E_IDLE);

    // Ignored start at cycle 5, sync reset at cycle 8, then default config.
    start = 1'b1;                       // cycle 0
    phase(E_ER, 2);
    tick(E_GAP);
    tick(E_EX);
    tick(E_EX);                         // cycle 5
    start = 1'b1;
    tick(E_EX);
    tick(E_GAP);
    tick(E_CV);                         // cycle 8
    reset = 1'b1;
    tick(E_IDLE);                       // cycle 9
    start = 1'b1;
    frame(5, 255, 255, 5);
    tick(E_IDLE);

    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
